// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access runs IDLE -> ACCESS -> RESP, with a completion pulse in RESP.
module data_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    logic [1:0]        state_reg;
    logic              sel_b_reg;
    logic              we_reg;
    logic              err_reg;
    logic              last_b_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] a_rdata_reg;
    logic [DATA_W-1:0] b_rdata_reg;

    logic grant_b;
    logic in_range;
    logic in_access;
    logic in_resp;

    // B wins only if A is idle or A was the one served last.
    assign grant_b   = b_req & (~a_req | ~last_b_reg);
    assign in_range  = addr_reg < DEPTH_W;
    assign in_access = (state_reg == ACCESS);
    assign in_resp   = (state_reg == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            sel_b_reg   <= 1'b0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            last_b_reg  <= 1'b1;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            a_rdata_reg <= '0;
            b_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (a_req | b_req) begin
                        state_reg <= ACCESS;
                        sel_b_reg <= grant_b;
                        we_reg    <= grant_b ? b_we    : a_we;
                        addr_reg  <= grant_b ? b_addr  : a_addr;
                        wdata_reg <= grant_b ? b_wdata : a_wdata;
                    end
                end
                ACCESS: begin
                    state_reg  <= RESP;
                    err_reg    <= ~in_range;
                    last_b_reg <= sel_b_reg;
                    // An out-of-range read returns zero rather than stale data.
                    if (!we_reg) begin
                        if (sel_b_reg) b_rdata_reg <= in_range ? mem_rdata : '0;
                        else           a_rdata_reg <= in_range ? mem_rdata : '0;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign mem_read  = in_access & ~we_reg & in_range;
    assign mem_write = in_access &  we_reg & in_range;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    assign a_done  = in_resp & ~sel_b_reg;
    assign b_done  = in_resp &  sel_b_reg;
    assign a_err   = a_done & err_reg;
    assign b_err   = b_done & err_reg;
    assign a_rdata = a_rdata_reg;
    assign b_rdata = b_rdata_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data memory.
module tb_data_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              a_done, a_err;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_done, b_err;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    logic [DATA_W-1:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    int                obs_cycles, obs_reads, obs_writes;
    logic              obs_done, obs_err;
    logic [ADDR_W-1:0] obs_addr;
    logic [DATA_W-1:0] obs_rdata;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;

    data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Issue one access on a single port and follow it until done (bounded).
    task automatic run_access(input bit use_b, input bit we,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        @(negedge clk);
        if (use_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else       begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        obs_cycles = 0; obs_reads = 0; obs_writes = 0;
        obs_done = 0; obs_err = 0; obs_addr = '0; obs_rdata = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) obs_addr = mem_addr;
            if (mem_read)  obs_reads++;
            if (mem_write) obs_writes++;
            if (use_b ? b_done : a_done) begin
                obs_cycles = c; obs_done = 1;
                obs_err   = use_b ? b_err : a_err;
                obs_rdata = use_b ? b_rdata : a_rdata;
                break;
            end
        end
        a_req = 0; b_req = 0;
        $display("txn port=%s we=%0d addr=%0d wdata=0x%0h -> done=%0d cycles=%0d err=%0d rdata=0x%0h",
                 use_b ? "B" : "A", we, addr, wdata, obs_done, obs_cycles, obs_err, obs_rdata);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 0;
        a_req = 0; b_req = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, mem_read, mem_write, a_done, b_done, a_err, b_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, mem_read, mem_write, a_done, b_done, a_err, b_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, a_rdata, b_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0h wdata=%0h a_rdata=%0h b_rdata=%0h want all 0",
                     mem_addr, mem_wdata, a_rdata, b_rdata);
        end
        reset = 1;
        $display("txn reset released");
    endtask

    task automatic test_single_read();
        run_access(0, 0, 3, 0);
        checks++;
        if (obs_done !== 1'b1 || obs_cycles != 2) begin
            errors++;
            $display("FAIL a_read_latency: done=%0d cycles=%0d want done=1 cycles=2", obs_done, obs_cycles);
        end
        checks++;
        if (obs_reads != 1 || obs_writes != 0 || obs_addr !== 3) begin
            errors++;
            $display("FAIL a_read_strobe: reads=%0d writes=%0d addr=%0d want 1 0 3", obs_reads, obs_writes, obs_addr);
        end
        checks++;
        if (obs_rdata !== 32'd5 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL a_read_data: rdata=%0h err=%0d want 5 0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_write_read_b();
        run_access(1, 1, 7, 32'h2A);
        checks++;
        if (obs_writes != 1 || obs_reads != 0 || obs_addr !== 7 || obs_cycles != 2) begin
            errors++;
            $display("FAIL b_write_strobe: writes=%0d reads=%0d addr=%0d cycles=%0d want 1 0 7 2",
                     obs_writes, obs_reads, obs_addr, obs_cycles);
        end
        checks++;
        if (mem[7] !== 32'h2A || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL b_write_mem: mem[7]=%0h err=%0d want 2a 0", mem[7], obs_err);
        end
        run_access(1, 0, 7, 0);
        checks++;
        if (obs_rdata !== 32'h2A || obs_reads != 1) begin
            errors++;
            $display("FAIL b_readback: rdata=%0h reads=%0d want 2a 1", obs_rdata, obs_reads);
        end
    endtask

    task automatic test_out_of_range();
        run_access(0, 0, 10, 0);
        checks++;
        if (obs_reads != 0 || obs_writes != 0) begin
            errors++;
            $display("FAIL oor_read_strobe: reads=%0d writes=%0d want 0 0", obs_reads, obs_writes);
        end
        checks++;
        if (obs_done !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin
            errors++;
            $display("FAIL oor_read_resp: done=%0d err=%0d rdata=%0h want 1 1 0", obs_done, obs_err, obs_rdata);
        end
        // Out-of-range write must not touch B's previous read data.
        run_access(1, 1, 12, 32'hDEAD);
        checks++;
        if (obs_writes != 0 || obs_err !== 1'b1 || obs_rdata !== 32'h2A) begin
            errors++;
            $display("FAIL oor_write: writes=%0d err=%0d rdata=%0h want 0 1 2a", obs_writes, obs_err, obs_rdata);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        mem[4] = 32'h44;
        @(negedge clk);
        b_req = 1; b_we = 1; b_addr = 4; b_wdata = 32'h77;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_access: mem_write=%0d want 1", mem_write);
        end
        reset = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%0d mem_write=%0d want 0 0", busy, mem_write);
        end
        b_req = 0;
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (b_done) saw_done = 1;
        end
        reset = 1;
        checks++;
        if (saw_done !== 1'b0 || mem[4] !== 32'h44) begin
            errors++;
            $display("FAIL abort_effect: b_done_seen=%0d mem[4]=%0h want 0 44", saw_done, mem[4]);
        end
        $display("txn reset abort of B write done");
        // Both request after release: A must win the first contention.
        a_req = 1; a_we = 0; a_addr = 3;
        b_req = 1; b_we = 0; b_addr = 7;
        repeat (2) @(negedge clk);
        checks++;
        if (a_done !== 1'b1 || b_done !== 1'b0 || a_rdata !== 32'd5) begin
            errors++;
            $display("FAIL post_reset_first: a_done=%0d b_done=%0d a_rdata=%0h want 1 0 5", a_done, b_done, a_rdata);
        end
        a_req = 0; b_req = 0;
        $display("txn post-reset contention first grant A");
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_a, exp_b;
        mem[1] = 32'h11; mem[2] = 32'h22;
        apply_reset();
        a_req = 1; a_we = 0; a_addr = 1;
        b_req = 1; b_we = 0; b_addr = 2;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_a = (c == 2) || (c == 8);
            exp_b = (c == 5) || (c == 11);
            checks++;
            if (a_done !== exp_a || b_done !== exp_b) begin
                errors++;
                $display("FAIL rr_cycle%0d: a_done=%0d b_done=%0d want %0d %0d", c, a_done, b_done, exp_a, exp_b);
            end
            if (exp_a || exp_b)
                $display("txn rr cycle=%0d grant=%s", c, exp_a ? "A" : "B");
        end
        a_req = 0; b_req = 0;
        checks++;
        if (a_rdata !== 32'h11 || b_rdata !== 32'h22) begin
            errors++;
            $display("FAIL rr_data: a_rdata=%0h b_rdata=%0h want 11 22", a_rdata, b_rdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: busy=%0d want 0", busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        mem[3] = 32'd5;
        test_reset();
        test_single_read();
        test_write_read_b();
        test_out_of_range();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - DATA_W, 32, data word width
 - ADDR_W, 32, word address width
 - DEPTH, 10, number of implemented memory words; legal addresses are 0..DEPTH-1
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
 - clk  in  1  clock; all state changes on posedge
 - reset  in  1  asynchronous active-low reset
 - a_req  in  1  requester A (pipeline MEM stage) access request, held until a_done
 - a_we  in  1  A: 1 = write, 0 = read
 - a_addr  in  ADDR_W  A word address
 - a_wdata  in  DATA_W  A write data
 - a_done  out  1  A single-cycle completion pulse
 - a_err  out  1  A address-out-of-range flag, valid with a_done
 - a_rdata  out  DATA_W  A read data, valid with a_done, held until next A read completes
 - b_req, b_we, b_addr, b_wdata, b_done, b_err, b_rdata  same as A, for requester B (loader/debug port)
 - mem_addr  out  ADDR_W  to data memory address
 - mem_read  out  1  to data memory read strobe
 - mem_write  out  1  to data memory write strobe
 - mem_wdata  out  DATA_W  to data memory write data
 - mem_rdata  in  DATA_W  from data memory read data
 - busy  out  1  high in any state other than IDLE

Function
REQ-004 FSM states SHALL be IDLE, ACCESS, RESP; transitions IDLE->ACCESS when a_req|b_req, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-005 In IDLE with a request present, the arbiter SHALL select the winner, register its we/addr/wdata and its identity, and enter ACCESS on the next posedge.
REQ-006 Arbitration SHALL be round-robin: when both requests are asserted, the requester not served last wins; the last-served pointer resets to B so that A wins the first contention.
REQ-007 When only one request is asserted, that requester SHALL win regardless of the pointer.
REQ-008 In ACCESS, mem_addr and mem_wdata SHALL present the registered values, and exactly one of mem_read (read) or mem_write (write) SHALL be high for that one cycle.
REQ-009 If the registered address is >= DEPTH, the arbiter SHALL assert neither mem_read nor mem_write in ACCESS and SHALL flag an error.
REQ-010 On entering RESP, a legal read SHALL capture mem_rdata into the winner's rdata register; writes and errors SHALL leave rdata unchanged, except that an erroneous read SHALL load 0.
REQ-011 In RESP, the winner's done SHALL pulse high for exactly one cycle, with err high only for out-of-range accesses, and the last-served pointer SHALL update to the winner.
REQ-012 Latency from request sampled in IDLE to done SHALL be 2 cycles; peak throughput SHALL be one access per 3 cycles.
REQ-013 A requester SHALL hold req and its operands stable until done; the arbiter SHALL ignore operand changes after capture, and deassertion of req after capture SHALL NOT abort the transaction.
REQ-014 A request still asserted in RESP SHALL NOT be re-granted in that cycle; it SHALL be considered in the following IDLE cycle. A requester SHALL drop req in the cycle after done unless it issues a new access.
REQ-015 mem_read, mem_write, and both done signals SHALL be zero outside the states defined above; mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-016 While reset=0, the state SHALL be IDLE; busy, mem_read, mem_write, a_done, b_done, a_err, and b_err SHALL be 0; mem_addr, mem_wdata, a_rdata, and b_rdata SHALL be 0; and the pointer SHALL be B.
REQ-017 Reset asserted mid-transaction SHALL abort it immediately with no done pulse; the memory write SHALL NOT be issued if reset arrives before ACCESS.

Verification
REQ-018 A read at address 3, memory holding 5 -> mem_read high one cycle; 2 cycles later a_done=1, a_rdata=5, a_err=0.
REQ-019 B writes 0x2A at address 7, then B reads address 7 -> mem_write high one cycle with mem_addr=7; the read returns b_rdata=0x2A.
REQ-020 A and B both request from reset, repeatedly -> grants alternate A, B, A, B; each done is spaced 3 cycles apart.
REQ-021 A reads address 10 (DEPTH=10) -> no mem_read or mem_write; a_done=1, a_err=1, a_rdata=0.
REQ-022 Reset dropped to 0 in ACCESS of a B write -> busy=0 and b_done is never pulsed; after release, an A read proceeds normally, with A winning the first contention.
